rob_multi_commit: RTL and testbench
===================================

# rob_multi_commit

Parametrised reorder buffer for the out-of-order MIPS core, replacing the single-commit, flush-everything ROB. It sits between decode/rename (allocation) and the architectural register file, store port and branch predictor (retirement). It adds:

- up to COMMIT_W in-order retirements per cycle;
- CDB_PORTS simultaneous writebacks;
- selective squash of entries younger than a mispredicted branch;
- same-cycle CDB forwarding on the operand lookup ports.

## Interface
- DEPTH, 16, entries; power of 2, at least 4
- COMMIT_W, 2, retire slots per cycle (1..4)
- CDB_PORTS, 2, writeback ports
- DATA_W, 32, value width
- ADDR_W, 16, memory/PC address width
- PREG_W, 6, physical register tag width
- TAG_W = clog2(DEPTH), derived
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  full flush (exception/mtc0); clears the whole ROB
- disp_valid  in  1  allocate one entry; caller gates it with !full
- disp_type  in  2  0 REG, 1 JUMP, 2 ST, 3 BR
- disp_jump_reg  in  1  JUMP is jr/jalr; entry waits for CDB
- disp_pc  in  ADDR_W  instruction PC
- disp_lreg  in  5  logical destination register
- disp_preg  in  PREG_W  physical destination register
- disp_tag  out  TAG_W  tag that the next allocation receives
- full, empty  out  1  occupancy flags
- count  out  TAG_W+1  occupied entries
- cdb_valid  in  CDB_PORTS  per-port writeback strobe
- cdb_tag  in  CDB_PORTS*TAG_W  writeback tags, port-major
- cdb_data  in  CDB_PORTS*DATA_W  writeback values, port-major
- st_valid, st_tag, st_addr, st_data  in  1/TAG_W/ADDR_W/DATA_W  store address+data resolution
- squash_valid, squash_tag  in  1/TAG_W  discard all entries strictly younger than squash_tag
- mem_stall  in  1  store port busy
- lk_tag  in  2*TAG_W  operand lookup tags (rs, rt)
- lk_ready, lk_data  out  2 / 2*DATA_W  lookup results
- cm_valid  out  COMMIT_W  slot i retires this cycle
- cm_type, cm_lreg, cm_preg, cm_data, cm_pc  out  per slot, flattened  retired entry fields
- cm_st_en, cm_st_addr, cm_st_data  out  1/ADDR_W/DATA_W  store write to memory
- cm_br_valid, cm_br_taken  out  1/1  branch retire; taken is (data != 0)

## Operation
**Storage and pointers**
- Circular buffer of DEPTH entries.
- rd_ptr and wr_ptr are TAG_W+1 bits with a wrap bit.
- empty = (pointers equal).
- full = (low bits equal and wrap bits differ).

**Allocation**
- Allocation writes entry wr_ptr and increments wr_ptr.
- ready at allocation = 1 only for JUMP with !disp_jump_reg; all other entries start not ready.
- disp_valid while full is ignored.

**Writeback**
- A CDB port or st_valid sets the tagged entry's value and ready = 1. A store also sets its address.
- Writebacks to tags outside [rd_ptr, wr_ptr) are ignored. Use the post-squash range when a squash occurs in the same cycle.
- Two ports hitting the same tag is illegal; the higher port index wins.

**Retirement**
- Slot i retires entry rd_ptr+i when all of the following hold:
  - the entry is occupied and ready;
  - slots 0..i-1 retire;
  - no older slot in this cycle retired a BR or ST.
- ST may retire only in slot 0, and only when !mem_stall.
- rd_ptr advances by the number of retiring slots.
- cm_valid is gated off by flush.
- REG with lreg == 0 retires with cm_valid=1; the consumer ignores it.

**Squash**
- wr_ptr <= rd_ptr + ((squash_tag - rd_ptr) mod DEPTH) + 1. The squash_tag entry itself is kept.
- Squash has priority over same-cycle dispatch: the dispatch is dropped.
- Same-cycle retirements of older entries proceed.

**Priority:** reset > flush > squash > dispatch. Writeback and retirement are concurrent with squash.

**Lookup ports**
- Report the entry's ready/value.
- If a same-cycle CDB port targets lk_tag, forward cdb_data with ready = 1.

## Timing
- Reset (and flush) values: pointers 0, all entries invalid and not ready, cm_* 0, cm_st_en 0, cm_br_valid 0, full 0, empty 1, count 0, disp_tag 0.
- Dispatch at edge N. The entry is visible to lookups in cycle N+1.
- CDB write at edge N+1. Combinational cm_valid in cycle N+2; the entry is freed at edge N+2.
- A non-register JUMP can retire in cycle N+1.
- full/empty/count are registered-state views. A retirement in the same cycle does not clear full for that cycle's dispatch.
- The wrap bit flips every DEPTH allocations. Full and empty must be correct across any number of wraps.
- mem_stall holds an ST head and every younger entry. Nothing retires behind a stalled ST.

## Test plan
- Fill: 16 REG dispatches, no writeback -> full=1, count=16, a 17th dispatch is ignored; then CDB writes to tags 0,1 on both ports -> cm_valid=2'b11 next cycle, count=14.
- Out-of-order writeback: tags 0..3 dispatched, CDB on tag 3 then 1 then 0 -> tags 0 and 1 retire together, tag 2 blocks, tag 3 stays held.
- Store stall: ST at head ready, mem_stall=1 for 3 cycles -> no retire. On release: cm_st_en=1 with the correct address/data, only slot 0 valid that cycle.
- Squash: tags 5..12 in flight, squash_tag=7 -> count drops to 3, disp_tag=8; a same-cycle CDB to tag 9 is ignored and a new dispatch receives tag 8.
- Wrap: 40 dispatch/retire cycles with DEPTH=16 -> tags wrap 15->0, full and empty never both 1, count matches the scoreboard.
- Forwarding plus flush: lk_tag=4 with a same-cycle CDB to tag 4 data=0xDEAD -> lk_ready=1, lk_data=0xDEAD. flush in the next cycle -> empty=1 and cm_valid=0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// Reorder buffer: multi-slot in-order retirement, multi-port CDB writeback,
// selective squash of younger entries and CDB forwarding on operand lookups.
module rob_multi_commit #(
  parameter int DEPTH     = 16,
  parameter int COMMIT_W  = 2,
  parameter int CDB_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int PREG_W    = 6,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 disp_valid,
  input  logic [1:0]                           disp_type,
  input  logic                                 disp_jump_reg,
  input  logic [ADDR_W-1:0]                    disp_pc,
  input  logic [4:0]                           disp_lreg,
  input  logic [PREG_W-1:0]                    disp_preg,
  output logic [TAG_W-1:0]                     disp_tag,
  output logic                                 full,
  output logic                                 empty,
  output logic [TAG_W:0]                       count,
  input  logic [CDB_PORTS-1:0]                 cdb_valid,
  input  logic [CDB_PORTS-1:0][TAG_W-1:0]      cdb_tag,
  input  logic [CDB_PORTS-1:0][DATA_W-1:0]     cdb_data,
  input  logic                                 st_valid,
  input  logic [TAG_W-1:0]                     st_tag,
  input  logic [ADDR_W-1:0]                    st_addr,
  input  logic [DATA_W-1:0]                    st_data,
  input  logic                                 squash_valid,
  input  logic [TAG_W-1:0]                     squash_tag,
  input  logic                                 mem_stall,
  input  logic [1:0][TAG_W-1:0]                lk_tag,
  output logic [1:0]                           lk_ready,
  output logic [1:0][DATA_W-1:0]               lk_data,
  output logic [COMMIT_W-1:0]                  cm_valid,
  output logic [COMMIT_W-1:0][1:0]             cm_type,
  output logic [COMMIT_W-1:0][4:0]             cm_lreg,
  output logic [COMMIT_W-1:0][PREG_W-1:0]      cm_preg,
  output logic [COMMIT_W-1:0][DATA_W-1:0]      cm_data,
  output logic [COMMIT_W-1:0][ADDR_W-1:0]      cm_pc,
  output logic                                 cm_st_en,
  output logic [ADDR_W-1:0]                    cm_st_addr,
  output logic [DATA_W-1:0]                    cm_st_data,
  output logic                                 cm_br_valid,
  output logic                                 cm_br_taken
);
  localparam int PTR_W = TAG_W + 1;
  localparam logic [1:0] T_REG = 2'd0, T_JUMP = 2'd1, T_ST = 2'd2, T_BR = 2'd3;

  typedef struct packed {
    logic [1:0]        typ;
    logic [4:0]        lreg;
    logic [PREG_W-1:0] preg;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t                            ent [DEPTH];
  logic [DEPTH-1:0]                  rdy;
  logic [PTR_W-1:0]                  rd_ptr, wr_ptr, cnt, cnt_post, n_ret;
  logic [TAG_W-1:0]                  rd_idx, wr_idx, sq_off;
  logic [COMMIT_W-1:0][TAG_W-1:0]    slot_idx;
  logic [COMMIT_W-1:0]               retire;
  logic [CDB_PORTS-1:0]              wb_ok;
  logic                              st_ok, do_disp;

  function automatic logic in_range(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] base,
                                    input logic [PTR_W-1:0] n);
    logic [TAG_W-1:0] off;
    off = t - base;
    return {1'b0, off} < n;
  endfunction

  assign rd_idx   = rd_ptr[TAG_W-1:0];
  assign wr_idx   = wr_ptr[TAG_W-1:0];
  assign cnt      = wr_ptr - rd_ptr;
  assign sq_off   = squash_tag - rd_idx;
  // Occupancy seen by writeback/retire this cycle: a squash shrinks it immediately.
  assign cnt_post = squash_valid ? {1'b0, sq_off} + PTR_W'(1) : cnt;
  assign empty    = (rd_ptr == wr_ptr);
  assign full     = (rd_idx == wr_idx) && (rd_ptr[TAG_W] != wr_ptr[TAG_W]);
  assign count    = cnt;
  assign disp_tag = wr_idx;
  assign st_ok    = st_valid && in_range(st_tag, rd_idx, cnt_post);
  assign do_disp  = disp_valid && !full && !squash_valid;

  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_wb
    assign wb_ok[p] = cdb_valid[p] && in_range(cdb_tag[p], rd_idx, cnt_post);
  end

  // Retire chain: stops at the first non-ready slot, after any BR/ST, and a
  // store may only leave from slot 0 while the store port is free.
  always_comb begin
    logic ok, chain;
    retire = '0;
    n_ret  = '0;
    ok     = 1'b0;
    chain  = !flush;
    for (int i = 0; i < COMMIT_W; i++) begin
      ok = chain && (PTR_W'(i) < cnt_post) && rdy[slot_idx[i]];
      if (ent[slot_idx[i]].typ == T_ST) ok = ok && (i == 0) && !mem_stall;
      retire[i] = ok;
      n_ret     = n_ret + PTR_W'(ok);
      chain     = ok && (ent[slot_idx[i]].typ == T_REG || ent[slot_idx[i]].typ == T_JUMP);
    end
  end

  for (genvar i = 0; i < COMMIT_W; i++) begin : g_slot
    assign slot_idx[i] = rd_idx + TAG_W'(i);
    assign cm_valid[i] = retire[i];
    assign cm_type[i]  = retire[i] ? ent[slot_idx[i]].typ  : '0;
    assign cm_lreg[i]  = retire[i] ? ent[slot_idx[i]].lreg : '0;
    assign cm_preg[i]  = retire[i] ? ent[slot_idx[i]].preg : '0;
    assign cm_data[i]  = retire[i] ? ent[slot_idx[i]].data : '0;
    assign cm_pc[i]    = retire[i] ? ent[slot_idx[i]].pc   : '0;
  end

  assign cm_st_en   = retire[0] && (ent[slot_idx[0]].typ == T_ST);
  assign cm_st_addr = cm_st_en ? ent[slot_idx[0]].addr : '0;
  assign cm_st_data = cm_st_en ? ent[slot_idx[0]].data : '0;

  always_comb begin
    cm_br_valid = 1'b0;
    cm_br_taken = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (retire[i] && ent[slot_idx[i]].typ == T_BR) begin
        cm_br_valid = 1'b1;
        cm_br_taken = (ent[slot_idx[i]].data != '0);
      end
    end
  end

  // Lookups: stored state first, then a same-cycle CDB hit overrides it.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lk_ready[l] = rdy[lk_tag[l]] && in_range(lk_tag[l], rd_idx, cnt);
      lk_data[l]  = ent[lk_tag[l]].data;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && cdb_tag[p] == lk_tag[l]) begin
          lk_ready[l] = 1'b1;
          lk_data[l]  = cdb_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      rdy    <= '0;
    end else begin
      rd_ptr <= rd_ptr + n_ret;
      for (int p = 0; p < CDB_PORTS; p++)
        if (wb_ok[p]) rdy[cdb_tag[p]] <= 1'b1;
      if (st_ok) rdy[st_tag] <= 1'b1;
      if (squash_valid) begin
        wr_ptr <= rd_ptr + cnt_post;
      end else if (do_disp) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        rdy[wr_idx] <= (disp_type == T_JUMP) && !disp_jump_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      for (int p = 0; p < CDB_PORTS; p++)
        if (wb_ok[p]) ent[cdb_tag[p]].data <= cdb_data[p];
      if (st_ok) begin
        ent[st_tag].data <= st_data;
        ent[st_tag].addr <= st_addr;
      end
      if (do_disp) begin
        ent[wr_idx].typ  <= disp_type;
        ent[wr_idx].lreg <= disp_lreg;
        ent[wr_idx].preg <= disp_preg;
        ent[wr_idx].pc   <= disp_pc;
        ent[wr_idx].data <= '0;
        ent[wr_idx].addr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: fill, out-of-order writeback, store
// stall, squash, forwarding/flush, pointer wrap and branch retirement.
module tb_rob_multi_commit;
  localparam int DEPTH = 16, COMMIT_W = 2, CDB_PORTS = 2, DATA_W = 32, ADDR_W = 16, PREG_W = 6;
  localparam int TAG_W = 4;

  logic clk = 1'b0, rst_n, flush, disp_valid, disp_jump_reg;
  logic [1:0] disp_type;
  logic [ADDR_W-1:0] disp_pc;
  logic [4:0] disp_lreg;
  logic [PREG_W-1:0] disp_preg;
  logic [TAG_W-1:0] disp_tag;
  logic full, empty;
  logic [TAG_W:0] count;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [CDB_PORTS-1:0][TAG_W-1:0] cdb_tag;
  logic [CDB_PORTS-1:0][DATA_W-1:0] cdb_data;
  logic st_valid, squash_valid, mem_stall;
  logic [TAG_W-1:0] st_tag, squash_tag;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0][TAG_W-1:0] lk_tag;
  logic [1:0] lk_ready;
  logic [1:0][DATA_W-1:0] lk_data;
  logic [COMMIT_W-1:0] cm_valid;
  logic [COMMIT_W-1:0][1:0] cm_type;
  logic [COMMIT_W-1:0][4:0] cm_lreg;
  logic [COMMIT_W-1:0][PREG_W-1:0] cm_preg;
  logic [COMMIT_W-1:0][DATA_W-1:0] cm_data;
  logic [COMMIT_W-1:0][ADDR_W-1:0] cm_pc;
  logic cm_st_en, cm_br_valid, cm_br_taken;
  logic [ADDR_W-1:0] cm_st_addr;
  logic [DATA_W-1:0] cm_st_data;

  int checks = 0, errors = 0;

  rob_multi_commit #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .CDB_PORTS(CDB_PORTS),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_type(disp_type),
    .disp_jump_reg(disp_jump_reg), .disp_pc(disp_pc), .disp_lreg(disp_lreg),
    .disp_preg(disp_preg), .disp_tag(disp_tag), .full(full), .empty(empty), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .st_valid(st_valid),
    .st_tag(st_tag), .st_addr(st_addr), .st_data(st_data), .squash_valid(squash_valid),
    .squash_tag(squash_tag), .mem_stall(mem_stall), .lk_tag(lk_tag), .lk_ready(lk_ready),
    .lk_data(lk_data), .cm_valid(cm_valid), .cm_type(cm_type), .cm_lreg(cm_lreg),
    .cm_preg(cm_preg), .cm_data(cm_data), .cm_pc(cm_pc), .cm_st_en(cm_st_en),
    .cm_st_addr(cm_st_addr), .cm_st_data(cm_st_data), .cm_br_valid(cm_br_valid),
    .cm_br_taken(cm_br_taken));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    flush = 0; disp_valid = 0; disp_type = 0; disp_jump_reg = 0; disp_pc = 0;
    disp_lreg = 0; disp_preg = 0; cdb_valid = 0; st_valid = 0; squash_valid = 0;
    mem_stall = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic nxt();
    @(posedge clk); #1; clr();
  endtask

  task automatic disp(input logic [1:0] t, input int n);
    disp_valid = 1; disp_type = t; disp_jump_reg = 0;
    disp_pc = ADDR_W'(n * 4); disp_lreg = 5'(n + 1); disp_preg = PREG_W'(n);
  endtask

  task automatic cdb(input int p, input int t, input logic [DATA_W-1:0] d);
    cdb_valid[p] = 1'b1; cdb_tag[p] = TAG_W'(t); cdb_data[p] = d;
  endtask

  initial begin
    int sb_cnt;
    rst_n = 0; clr(); lk_tag = '0; cdb_tag = '0; cdb_data = '0;
    st_tag = 0; st_addr = 0; st_data = 0; squash_tag = 0;
    nxt(); nxt();
    rst_n = 1; #1;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_disp_tag", disp_tag, 0); chk("rst_cm_valid", cm_valid, 0);
    chk("rst_st_en", cm_st_en, 0); chk("rst_br_valid", cm_br_valid, 0);

    // Fill to 16, 17th ignored, then two tags retire together
    for (int i = 0; i < 16; i++) begin
      nxt(); disp(2'd0, i); #1; chk("fill_tag", disp_tag, i);
    end
    nxt(); #1;
    chk("fill_full", full, 1); chk("fill_count", count, 16); chk("fill_empty", empty, 0);
    disp(2'd0, 16);
    nxt(); #1;
    chk("fill_17_count", count, 16); chk("fill_17_tag", disp_tag, 0);
    cdb(0, 0, 32'h100); cdb(1, 1, 32'h101);
    nxt(); #1;
    chk("fill_cm_valid", cm_valid, 2'b11); chk("fill_cm_data0", cm_data[0], 32'h100);
    chk("fill_cm_data1", cm_data[1], 32'h101); chk("fill_cm_lreg0", cm_lreg[0], 1);
    chk("fill_cm_preg1", cm_preg[1], 1);
    nxt(); #1;
    chk("fill_count14", count, 14); chk("fill_notfull", full, 0); chk("fill_cm_idle", cm_valid, 0);
    flush = 1;
    nxt(); #1; chk("flush1_empty", empty, 1);

    // Out-of-order writeback: 3, 1, 0 then 2
    for (int i = 0; i < 4; i++) begin nxt(); disp(2'd0, i); end
    nxt(); cdb(0, 3, 32'h33);
    nxt(); #1; chk("ooo_wait3", cm_valid, 0); cdb(0, 1, 32'h11);
    nxt(); #1; chk("ooo_wait1", cm_valid, 0); cdb(0, 0, 32'h10);
    nxt(); #1;
    chk("ooo_ret01", cm_valid, 2'b11); chk("ooo_d0", cm_data[0], 32'h10); chk("ooo_d1", cm_data[1], 32'h11);
    nxt(); #1;
    chk("ooo_block2", cm_valid, 0); chk("ooo_count2", count, 2);
    cdb(1, 2, 32'h22);
    nxt(); #1;
    chk("ooo_ret23", cm_valid, 2'b11); chk("ooo_d2", cm_data[0], 32'h22); chk("ooo_d3", cm_data[1], 32'h33);
    nxt(); #1; chk("ooo_empty", empty, 1);

    // Store stall: ST at tag 4, REG at tag 5
    nxt(); disp(2'd2, 4);
    nxt(); disp(2'd0, 5);
    nxt(); st_valid = 1; st_tag = 4; st_addr = 16'h1234; st_data = 32'hCAFE; cdb(0, 5, 32'h55);
    for (int i = 0; i < 3; i++) begin
      nxt(); mem_stall = 1; #1;
      chk("st_stall_valid", cm_valid, 0); chk("st_stall_en", cm_st_en, 0);
    end
    nxt(); #1;
    chk("st_rel_valid", cm_valid, 2'b01); chk("st_rel_en", cm_st_en, 1);
    chk("st_rel_addr", cm_st_addr, 16'h1234); chk("st_rel_data", cm_st_data, 32'hCAFE);
    chk("st_rel_type", cm_type[0], 2);
    nxt(); #1;
    chk("st_next_valid", cm_valid, 2'b01); chk("st_next_data", cm_data[0], 32'h55);
    nxt(); #1; chk("st_empty", empty, 1);
    flush = 1;

    // Squash: tags 0..12 dispatched, 0..4 retired, squash at 7
    for (int i = 0; i < 13; i++) begin nxt(); disp(2'd0, i); end
    nxt(); cdb(0, 0, 32'h0); cdb(1, 1, 32'h1);
    nxt(); #1; chk("sq_ret01", cm_valid, 2'b11); cdb(0, 2, 32'h2); cdb(1, 3, 32'h3);
    nxt(); #1; chk("sq_ret23", cm_valid, 2'b11); cdb(0, 4, 32'h4);
    nxt(); #1; chk("sq_ret4", cm_valid, 2'b01);
    nxt(); #1;
    chk("sq_pre_count", count, 8); chk("sq_pre_tag", disp_tag, 13);
    squash_valid = 1; squash_tag = 7; cdb(0, 9, 32'h99); disp(2'd0, 20);
    nxt(); #1;
    chk("sq_count", count, 3); chk("sq_disp_tag", disp_tag, 8);
    disp(2'd0, 21);
    nxt(); lk_tag[0] = 8; lk_tag[1] = 9; #1;
    chk("sq_new_count", count, 4); chk("sq_new_tag", disp_tag, 9);
    chk("sq_lk_ready", lk_ready, 2'b00);
    flush = 1;

    // Forwarding, then flush gates a ready head
    nxt(); #1; chk("fw_empty0", empty, 1);
    for (int i = 0; i < 5; i++) begin nxt(); disp(2'd0, i); end
    nxt(); lk_tag[0] = 4; lk_tag[1] = 3; cdb(1, 4, 32'hDEAD); cdb(0, 0, 32'h77); #1;
    chk("fw_ready", lk_ready, 2'b01); chk("fw_data", lk_data[0], 32'hDEAD);
    nxt(); flush = 1; #1;
    chk("fl_cm_valid", cm_valid, 0); chk("fl_lk_ready", lk_ready[0], 1);
    chk("fl_lk_data", lk_data[0], 32'hDEAD);
    nxt(); #1;
    chk("fl_empty", empty, 1); chk("fl_count", count, 0); chk("fl_cm_idle", cm_valid, 0);

    // Wrap: 40 ready JUMPs, each retiring the cycle after allocation
    sb_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      nxt(); disp(2'd1, i); #1;
      chk("wrap_tag", disp_tag, i % 16);
      chk("wrap_count", count, sb_cnt);
      chk("wrap_flags", full && empty, 0);
      chk("wrap_cm_valid", cm_valid, (sb_cnt > 0) ? 2'b01 : 2'b00);
      if (sb_cnt > 0) chk("wrap_cm_pc", cm_pc[0], (i - 1) * 4);
      sb_cnt = 1;
    end
    nxt(); #1; chk("wrap_last", cm_valid, 2'b01);
    nxt(); #1; chk("wrap_drained", empty, 1); chk("wrap_tag40", disp_tag, 8);
    for (int i = 0; i < 16; i++) begin nxt(); disp(2'd0, i); end
    nxt(); #1;
    chk("wrap_full", full, 1); chk("wrap_full_empty", empty, 0); chk("wrap_full_count", count, 16);
    flush = 1;

    // Branch stops the retire chain
    nxt(); disp(2'd3, 0);
    nxt(); disp(2'd0, 1);
    nxt(); cdb(0, 0, 32'h1); cdb(1, 1, 32'h5);
    nxt(); #1;
    chk("br_valid_slots", cm_valid, 2'b01); chk("br_valid", cm_br_valid, 1); chk("br_taken", cm_br_taken, 1);
    nxt(); #1;
    chk("br_next_slots", cm_valid, 2'b01); chk("br_next_bv", cm_br_valid, 0);
    chk("br_next_data", cm_data[0], 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
